// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues in-order word fetches under a credit limit,
// queues returned words with their PCs, and hands them to decode one at a time.
// A redirect flushes the queue, retargets fetch and discards responses that
// belong to requests issued before the redirect.
module inst_fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              SW      = CW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0]   DEPTH_S = SW'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'(3);

    // Control state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    // Queue storage (data only, never reset)
    logic [31:0]     fifo_inst_q [DEPTH];
    logic [XLEN-1:0] fifo_pc_q   [DEPTH];

    // Per-cycle handshake decisions
    logic [SW-1:0]   credit_used;
    logic            head_valid;
    logic            req_valid;
    logic            req_fire;
    logic            resp_drop;
    logic            push_en;
    logic            pop_en;
    logic [XLEN-1:0] redirect_target;

    // Handshake decode: credit covers both queued entries and in-flight requests,
    // so a returning response always has a free slot. A redirect cycle issues
    // nothing and cancels any push or pop.
    always_comb begin
        credit_used     = {1'b0, count_q} + {1'b0, outstanding_q};
        head_valid      = (count_q != '0);
        req_valid       = rst_n && !redirect_valid && (credit_used < DEPTH_S);
        req_fire        = req_valid && imem_req_ready;
        resp_drop       = (drop_cnt_q != '0);
        push_en         = imem_resp_valid && !resp_drop && !redirect_valid;
        pop_en          = head_valid && inst_ready && !redirect_valid;
        redirect_target = redirect_pc & ALIGN_M;
    end

    // Next-state computation for PCs, counters and queue pointers
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect_valid) begin
            // Every request still in flight, minus one answered this cycle,
            // belongs to the old stream and must be discarded on return.
            fetch_pc_d    = redirect_target;
            resp_pc_d     = redirect_target;
            outstanding_d = outstanding_q - CW'(imem_resp_valid);
            drop_cnt_d    = outstanding_q - CW'(imem_resp_valid);
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push_en) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue write: instruction word tagged with the PC it was fetched from
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_inst_q[wr_ptr_q] <= imem_resp_data;
            fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = head_valid;
    assign inst           = head_valid ? fifo_inst_q[rd_ptr_q] : NOP;
    assign inst_pc        = head_valid ? fifo_pc_q[rd_ptr_q] : '0;

    a_outstanding_max: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= DEPTH_C);
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= DEPTH_C);
    a_credit_max: assert property (@(posedge clk) disable iff (!rst_n)
        credit_used <= DEPTH_S);
    a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch stream.
module tb_inst_fetch_buffer;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk;
    logic            rst_n;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;

    int errors = 0;
    int checks = 0;

    // Addresses accepted by the memory and not yet answered
    logic [31:0] pend[$];

    inst_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory contents as a function of address
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory bookkeeping at the end of a cycle, then advance to the next negedge
    task automatic tick();
        #1;
        if (imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
        if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
        @(negedge clk);
    endtask

    task automatic drive_resp(input bit v);
        if (v && pend.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(pend[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        pend.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; pend.delete();
        @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        @(negedge clk);
        rst_n = 1'b1; imem_req_ready = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] acc[$];
        logic [31:0] got[$];
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive_resp(1'b1);
            #1;
            if (c == 1) begin
                checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass: got inst_valid=%b want 0", inst_valid); end
            end
            if (c == 2) begin
                checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL stream_first_out: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
            end
            if (imem_req_valid && imem_req_ready) acc.push_back(imem_req_addr);
            if (inst_valid && inst_ready) begin
                got.push_back(inst_pc);
                checks++; if (inst !== inst_of(inst_pc)) begin errors++; $display("FAIL stream_inst: got %h want %h", inst, inst_of(inst_pc)); end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (i >= acc.size() || acc[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_req_addr[%0d]: got %h (n=%0d) want %h", i, (i < acc.size()) ? acc[i] : 32'hx, acc.size(), 32'(4 * i)); end
            checks++; if (i >= got.size() || got[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_inst_pc[%0d]: got %h (n=%0d) want %h", i, (i < got.size()) ? got[i] : 32'hx, got.size(), 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        int nacc = 0;
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive_resp(1'b1);
            #1;
            if (imem_req_valid && imem_req_ready) nacc++;
            if (c >= 3) begin
                checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled: got %b want 0 (cycle %0d)", imem_req_valid, c); end
                checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== inst_of(32'h0)) begin errors++; $display("FAIL bp_head_stable: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", inst_valid, inst_pc, inst, inst_of(32'h0)); end
            end
            tick();
        end
        checks++; if (nacc !== 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", nacc); end
        inst_ready = 1'b1;
        drive_resp(1'b1);
        tick();
        inst_ready = 1'b0;
        drive_resp(1'b1);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_req: got v=%b a=%h want v=1 a=8", imem_req_valid, imem_req_addr); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL bp_next_head: got v=%b pc=%h want v=1 pc=4", inst_valid, inst_pc); end
        tick();
    endtask

    task automatic test_redirect_drop();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        drive_resp(1'b0); tick();
        drive_resp(1'b0); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        drive_resp(1'b0);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_no_req_in_redirect: got %b want 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        drive_resp(1'b1);
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rd_drop1: got rv=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
        tick();
        drive_resp(1'b1);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL rd_resume_while_drop: got v=%b a=%h want v=1 a=100", imem_req_valid, imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_drop2_empty: got %b want 0", inst_valid); end
        tick();
        drive_resp(1'b1);
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_no_bypass: got %b want 0", inst_valid); end
        tick();
        drive_resp(1'b0);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== inst_of(32'h100)) begin errors++; $display("FAIL rd_first_after: got v=%b pc=%h i=%h want v=1 pc=100 i=%h", inst_valid, inst_pc, inst, inst_of(32'h100)); end
        tick();
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        drive_resp(1'b1); tick();
        drive_resp(1'b1); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        drive_resp(1'b1);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL rc_head_before: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
        tick();
        redirect_valid = 1'b0;
        drive_resp(1'b1);
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rc_flushed: got %b want 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin errors++; $display("FAIL rc_req_target: got v=%b a=%h want v=1 a=300", imem_req_valid, imem_req_addr); end
        tick();
        drive_resp(1'b1); tick();
        drive_resp(1'b0);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin errors++; $display("FAIL rc_first_after: got v=%b pc=%h want v=1 pc=300", inst_valid, inst_pc); end
        tick();
    endtask

    task automatic test_align_wrap();
        do_reset();
        imem_req_ready = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        drive_resp(1'b0);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL aw_redirect_blocks_req: got %b want 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL aw_align: got v=%b a=%h want v=1 a=200", imem_req_valid, imem_req_addr); end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL aw_top_addr: got v=%b a=%h want v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
        tick();
        drive_resp(1'b1);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL aw_wrap_addr: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
        tick();
        imem_req_ready = 1'b0;
        drive_resp(1'b1);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== inst_of(32'hFFFF_FFFC)) begin errors++; $display("FAIL aw_top_inst: got v=%b pc=%h i=%h want v=1 pc=fffffffc", inst_valid, inst_pc, inst); end
        tick();
        drive_resp(1'b0);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL aw_wrap_inst_pc: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        drive_resp(1'b0); tick();
        drive_resp(1'b1); tick();
        drive_resp(1'b0);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL ar_pre_state: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL ar_async_valids: got rv=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
        checks++; if (inst !== NOP || inst_pc !== 32'h0) begin errors++; $display("FAIL ar_async_outputs: got i=%h pc=%h want i=%h pc=0", inst, inst_pc, NOP); end
        pend.delete();
        imem_resp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL ar_restart: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] m_fetch;
        logic [31:0] m_resp_pc;
        logic [31:0] tgt;
        int          m_outst;
        int          m_drop;
        bit          redir;
        bit          exp_rv;
        bit          acc;
        bit          pop;
        bit          resp;
        do_reset();
        m_fetch = 32'h0; m_resp_pc = 32'h0; m_outst = 0; m_drop = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            drive_resp($urandom_range(0, 2) != 0);
            redir          = ($urandom_range(0, 31) == 0);
            redirect_valid = redir;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            #1;
            exp_rv = !redir && (q.size() + m_outst < DEPTH);
            checks++; if (imem_req_valid !== exp_rv) begin errors++; $display("FAIL rnd_req_valid @%0d: got %b want %b", cyc, imem_req_valid, exp_rv); end
            if (exp_rv) begin
                checks++; if (imem_req_addr !== m_fetch) begin errors++; $display("FAIL rnd_req_addr @%0d: got %h want %h", cyc, imem_req_addr, m_fetch); end
            end
            if (q.size() > 0) begin
                checks++; if (inst_valid !== 1'b1 || inst_pc !== q[0] || inst !== inst_of(q[0])) begin errors++; $display("FAIL rnd_head @%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", cyc, inst_valid, inst_pc, inst, q[0], inst_of(q[0])); end
            end else begin
                checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst !== NOP) begin errors++; $display("FAIL rnd_empty @%0d: got v=%b pc=%h i=%h want v=0 pc=0 i=%h", cyc, inst_valid, inst_pc, inst, NOP); end
            end
            acc  = exp_rv && imem_req_ready;
            pop  = (q.size() > 0) && inst_ready;
            resp = imem_resp_valid;
            if (redir) begin
                tgt       = {redirect_pc[31:2], 2'b00};
                q.delete();
                m_fetch   = tgt;
                m_resp_pc = tgt;
                m_outst   = m_outst - int'(resp);
                m_drop    = m_outst;
            end else begin
                if (pop) void'(q.pop_front());
                if (resp) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        q.push_back(m_resp_pc);
                        m_resp_pc = m_resp_pc + 32'd4;
                    end
                end
                if (acc) m_fetch = m_fetch + 32'd4;
                m_outst = m_outst + int'(acc) - int'(resp);
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_coincident();
        test_align_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
